aon_wakeup_timer: RTL and testbench
===================================

// Module: aon_wakeup_timer
// PURPOSE
// - Consumes the slow divided-clock level (32.768 kHz nominal) produced by the clock divider, on the same clk.
// - Detects its rising edges as ticks, prescales them, and counts them against a programmable threshold.
// - Raises a level interrupt plus a one-cycle wakeup pulse on expiry; sits in the AON block, configured over a simple register port.
// PARAMETERS
// - CNT_W       32  width of COUNT and THRESHOLD registers (8..32)
// - PRESCALE_W  12  width of tick prescaler; effective divide = PRESCALE+1
// PORTS
// - clk         in   1      single system clock
// - reset       in   1      synchronous, active-high reset
// - tick_in     in   1      divided-clock level from the clock divider, synchronous to clk
// - cfg_we      in   1      register write strobe
// - cfg_re      in   1      register read strobe
// - cfg_addr    in   2      register index
// - cfg_wdata   in   32     write data
// - cfg_rdata   out  32     read data, registered
// - irq_o       out  1      expiry interrupt, level, sticky until W1C
// - wakeup_o    out  1      one-cycle pulse on expiry
// BEHAVIOUR
// - Reset: all registers, cfg_rdata, irq_o, wakeup_o = 0; FSM=IDLE; tick_d <= tick_in (no spurious edge after reset release).
// - Registers (unused bits read 0):
//   0 CTRL: [0] enable, [1] autoreload, [8+:PRESCALE_W] prescale
//   1 THRESHOLD
//   2 COUNT (writable)
//   3 STATUS: [0] irq (W1C), [1] running (RO)
// - Read: cfg_rdata updates the cycle after cfg_re; holds its value otherwise. Write takes effect next cycle.
// - Edges: tick_rise = tick_in & ~tick_d; tick_d samples tick_in every cycle.
// - Prescaler: pre_cnt advances only in COUNTING on tick_rise. When pre_cnt==prescale, it emits cnt_pulse and clears to 0.
//   Prescale 0 -> one cnt_pulse per tick.
// - FSM:
//   - IDLE: enable=1 -> COUNTING; pre_cnt cleared.
//   - COUNTING: cnt_pulse -> COUNT+1. If new value >= max(THRESHOLD,1) -> EXPIRED. enable=0 -> IDLE; COUNT holds.
//   - EXPIRED (one cycle): irq set; wakeup_o=1. With autoreload -> COUNT=0, COUNTING; otherwise enable cleared -> IDLE, COUNT holds.
// - running = (FSM != IDLE).
// - Arithmetic: COUNT wraps at 2^CNT_W-1 -> 0 without expiry only if THRESHOLD > COUNT never satisfied; writes truncate to CNT_W.
// - Simultaneous events:
//   - COUNT write vs cnt_pulse: write wins, no increment.
//   - irq W1C vs expiry: set wins.
//   - THRESHOLD write vs cnt_pulse: compare uses the old threshold.
//   - enable=0 write vs expiry: expiry completes (irq, wakeup), then IDLE.
// - Writing THRESHOLD <= COUNT while COUNTING: expires on the next cnt_pulse.
// - Reset mid-operation: immediate return to reset state; no wakeup pulse.
// CONFIGURATION
// - AON_TIMER_AUTORELOAD_EN defined: CTRL[1] is implemented as described above.
// - AON_TIMER_AUTORELOAD_EN undefined: CTRL[1] reads 0 and ignores writes; always one-shot.
// TESTING
// - Reset with tick_in=1, release -> no tick counted; all outputs 0; STATUS reads 0.
// - prescale=0, THRESHOLD=3, enable -> wakeup_o pulse 1 cycle after the 3rd tick_in rise; irq_o=1; COUNT=3; running=0.
// - prescale=3, THRESHOLD=2 -> expiry on the 8th tick rise; COUNT reads 1 after the 4th rise.
// - Autoreload (macro on), THRESHOLD=2 -> wakeup_o every 2 ticks; COUNT cycles 1,0.
//   Macro off: CTRL[1] write 1, read back 0.
// - W1C on STATUS in the same cycle as expiry -> irq_o stays 1; a later W1C -> irq_o=0.
// - COUNT write 5 coinciding with cnt_pulse -> COUNT=5. Reset asserted in COUNTING -> COUNT=0, FSM IDLE, no wakeup.

Source files
------------

// File: rtl/aon_wakeup_timer.sv
// -----------------------------------------------------------------------------
// aon_wakeup_timer
//
// Always-on wakeup timer. Rising edges of the slow divided-clock level on
// tick_in are prescaled and counted against a programmable threshold. On
// expiry the block raises a sticky level interrupt and a one-cycle wakeup
// pulse. Configuration goes through a small register port.
//
// Optional feature macro: AON_TIMER_AUTORELOAD_EN
//   defined   -> CTRL[1] (autoreload) is implemented: after expiry COUNT
//                restarts from 0 and counting continues.
//   undefined -> CTRL[1] reads 0 and ignores writes; the timer is one-shot.
//
// Ports
//   clk        in   1    system clock
//   reset      in   1    synchronous, active-high reset
//   tick_in    in   1    divided-clock level, synchronous to clk
//   cfg_we     in   1    register write strobe
//   cfg_re     in   1    register read strobe
//   cfg_addr   in   2    register index (0 CTRL, 1 THRESHOLD, 2 COUNT, 3 STATUS)
//   cfg_wdata  in   32   write data
//   cfg_rdata  out  32   registered read data, updates the cycle after cfg_re
//   irq_o      out  1    expiry interrupt, sticky until write-1-to-clear
//   wakeup_o   out  1    one-cycle pulse while the expiry is being handled
//
// Register map (unused bits read 0)
//   0 CTRL      [0] enable, [1] autoreload, [8 +: PRESCALE_W] prescale
//   1 THRESHOLD [CNT_W-1:0]
//   2 COUNT     [CNT_W-1:0], writable
//   3 STATUS    [0] irq (W1C), [1] running (RO)
// -----------------------------------------------------------------------------
module aon_wakeup_timer #(
    parameter int CNT_W      = 32,
    parameter int PRESCALE_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        cfg_we,
    input  logic        cfg_re,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        irq_o,
    output logic        wakeup_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        EXPIRED  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  enable_q, enable_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]      threshold_q, threshold_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  irq_q, irq_d;
    logic                  tick_dly_q, tick_dly_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  autoreload;

    logic                  tick_rise;
    logic                  pre_wrap;
    logic [CNT_W-1:0]      count_inc;
    logic [CNT_W-1:0]      thr_eff;
    logic                  wr_ctrl, wr_thr, wr_count, wr_status;
    logic                  running;
    logic [31:0]           rd_val;

    // Bits of the write bus that no register stores are intentionally ignored.
    logic                  unused_wdata;
    assign unused_wdata = ^cfg_wdata;

`ifdef AON_TIMER_AUTORELOAD_EN
    logic autoreload_q, autoreload_d;

    always_comb begin
        autoreload_d = autoreload_q;
        if (wr_ctrl) begin
            autoreload_d = cfg_wdata[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            autoreload_q <= 1'b0;
        end else begin
            autoreload_q <= autoreload_d;
        end
    end

    assign autoreload = autoreload_q;
`else
    assign autoreload = 1'b0;
`endif

    assign tick_rise = tick_in & ~tick_dly_q;
    assign pre_wrap  = (pre_cnt_q == prescale_q);
    assign count_inc = count_q + CNT_W'(1);
    // A zero threshold behaves like a threshold of one.
    assign thr_eff   = (threshold_q == '0) ? CNT_W'(1) : threshold_q;
    assign running   = (state_q != IDLE);

    assign wr_ctrl   = cfg_we && (cfg_addr == 2'd0);
    assign wr_thr    = cfg_we && (cfg_addr == 2'd1);
    assign wr_count  = cfg_we && (cfg_addr == 2'd2);
    assign wr_status = cfg_we && (cfg_addr == 2'd3);

    // Next-state logic. Order matters: software writes are applied first, the
    // FSM then overrides where hardware must win (irq set, enable clear), and
    // a COUNT write is applied last so it beats any increment or reload.
    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        prescale_d  = prescale_q;
        pre_cnt_d   = pre_cnt_q;
        threshold_d = threshold_q;
        count_d     = count_q;
        irq_d       = irq_q;
        tick_dly_d  = tick_in;

        if (wr_ctrl) begin
            enable_d   = cfg_wdata[0];
            prescale_d = cfg_wdata[8 +: PRESCALE_W];
        end
        if (wr_thr) begin
            threshold_d = cfg_wdata[CNT_W-1:0];
        end
        if (wr_status && cfg_wdata[0]) begin
            irq_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (enable_q) begin
                    state_d   = COUNTING;
                    pre_cnt_d = '0;
                end
            end
            COUNTING: begin
                if (!enable_q) begin
                    state_d = IDLE;
                end else if (tick_rise) begin
                    if (pre_wrap) begin
                        pre_cnt_d = '0;
                        // The comparison uses the threshold currently held,
                        // even if software is rewriting it this cycle.
                        if (!wr_count) begin
                            count_d = count_inc;
                            if (count_inc >= thr_eff) begin
                                state_d = EXPIRED;
                                irq_d   = 1'b1;
                            end
                        end
                    end else begin
                        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
                    end
                end
            end
            EXPIRED: begin
                irq_d = 1'b1;
                if (autoreload && enable_q) begin
                    count_d   = '0;
                    pre_cnt_d = '0;
                    state_d   = COUNTING;
                end else begin
                    enable_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wr_count) begin
            count_d = cfg_wdata[CNT_W-1:0];
        end
    end

    // Read mux; cfg_rdata holds its value unless a read is strobed.
    always_comb begin
        rd_val = '0;
        case (cfg_addr)
            2'd0: begin
                rd_val[0]              = enable_q;
                rd_val[1]              = autoreload;
                rd_val[8 +: PRESCALE_W] = prescale_q;
            end
            2'd1: rd_val[CNT_W-1:0] = threshold_q;
            2'd2: rd_val[CNT_W-1:0] = count_q;
            2'd3: begin
                rd_val[0] = irq_q;
                rd_val[1] = running;
            end
            default: rd_val = '0;
        endcase
        rdata_d = cfg_re ? rd_val : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            enable_q    <= 1'b0;
            prescale_q  <= '0;
            pre_cnt_q   <= '0;
            threshold_q <= '0;
            count_q     <= '0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
            // Track the live level so a high tick_in at release is not an edge.
            tick_dly_q  <= tick_in;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            prescale_q  <= prescale_d;
            pre_cnt_q   <= pre_cnt_d;
            threshold_q <= threshold_d;
            count_q     <= count_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
            tick_dly_q  <= tick_dly_d;
        end
    end

    assign cfg_rdata = rdata_q;
    assign irq_o     = irq_q;
    assign wakeup_o  = (state_q == EXPIRED);

endmodule

// File: tb/tb_aon_wakeup_timer.sv
// -----------------------------------------------------------------------------
// tb_aon_wakeup_timer
//
// Directed and randomized bench for aon_wakeup_timer. Expected values come
// from plain arithmetic on the number of tick rises driven: with prescale p,
// COUNT after n rises is n/(p+1) and one-shot expiry happens on rise
// (p+1)*max(threshold,1).
// -----------------------------------------------------------------------------
module tb_aon_wakeup_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_in;
    logic        cfg_we;
    logic        cfg_re;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        irq_o;
    logic        wakeup_o;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_THR  = 2'd1;
    localparam logic [1:0] A_CNT  = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    aon_wakeup_timer #(.CNT_W(32), .PRESCALE_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .cfg_we    (cfg_we),
        .cfg_re    (cfg_re),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_o     (irq_o),
        .wakeup_o  (wakeup_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        cfg_re = 1'b1; cfg_addr = a;
        @(posedge clk); #1;
        cfg_re = 1'b0;
        d = cfg_rdata;
    endtask

    // One rise of tick_in. wk_now: wakeup_o just after the rise is taken;
    // wk_next: wakeup_o one cycle later.
    task automatic do_tick(output logic wk_now, output logic wk_next);
        @(posedge clk); #1;
        tick_in = 1'b1;
        @(posedge clk); #1;
        tick_in = 1'b0;
        wk_now = wakeup_o;
        @(posedge clk); #1;
        wk_next = wakeup_o;
    endtask

    // Clear irq, zero COUNT, program threshold and control, let FSM start.
    task automatic arm(input logic [31:0] thr, input logic [31:0] ctrl);
        do_write(A_STAT, 32'h1);
        do_write(A_CNT, 32'h0);
        do_write(A_THR, thr);
        do_write(A_CTRL, ctrl);
        idle(2);
    endtask

    initial begin
        logic [31:0] rd;
        logic        w0, w1;
        int          p, thr, total;

        reset = 1'b1; tick_in = 1'b1;
        cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        idle(3);
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        check("rst_wakeup", {31'b0, wakeup_o}, 32'h0);
        check("rst_rdata", cfg_rdata, 32'h0);
        reset = 1'b0;
        idle(3);
        check("rel_wakeup", {31'b0, wakeup_o}, 32'h0);
        do_read(A_STAT, rd);  check("rel_status", rd, 32'h0);
        do_read(A_CNT, rd);   check("rel_count", rd, 32'h0);
        tick_in = 1'b0;

        // One-shot, prescale 0, threshold 3
        arm(32'd3, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            do_tick(w0, w1);
            check($sformatf("os3_wake_%0d", i), {31'b0, w0}, {31'b0, (i == 3)});
            check($sformatf("os3_wake_after_%0d", i), {31'b0, w1}, 32'h0);
        end
        check("os3_irq", {31'b0, irq_o}, 32'h1);
        do_read(A_CNT, rd);   check("os3_count", rd, 32'd3);
        do_read(A_STAT, rd);  check("os3_status", rd, 32'h1);
        do_read(A_CTRL, rd);  check("os3_ctrl_en_cleared", rd, 32'h0);
        do_write(A_STAT, 32'h1);
        idle(1);
        check("os3_w1c", {31'b0, irq_o}, 32'h0);

        // Prescale 3, threshold 2
        arm(32'd2, 32'h301);
        do_read(A_CTRL, rd);  check("ps3_ctrl", rd, 32'h301);
        do_read(A_STAT, rd);  check("ps3_running", rd, 32'h2);
        for (int i = 1; i <= 8; i++) begin
            do_tick(w0, w1);
            check($sformatf("ps3_wake_%0d", i), {31'b0, w0}, {31'b0, (i == 8)});
            do_read(A_CNT, rd);
            check($sformatf("ps3_count_%0d", i), rd, 32'(i / 4));
        end

        // W1C in the expiry cycle loses to the set
        arm(32'd1, 32'h1);
        @(posedge clk); #1;
        tick_in = 1'b1;
        @(posedge clk); #1;
        tick_in = 1'b0;
        check("w1c_race_wake", {31'b0, wakeup_o}, 32'h1);
        cfg_we = 1'b1; cfg_addr = A_STAT; cfg_wdata = 32'h1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check("w1c_race_irq", {31'b0, irq_o}, 32'h1);
        do_write(A_STAT, 32'h1);
        idle(1);
        check("w1c_later_irq", {31'b0, irq_o}, 32'h0);

        // COUNT write coinciding with a count pulse
        arm(32'd100, 32'h1);
        @(posedge clk); #1;
        tick_in = 1'b1;
        cfg_we = 1'b1; cfg_addr = A_CNT; cfg_wdata = 32'd5;
        @(posedge clk); #1;
        tick_in = 1'b0; cfg_we = 1'b0;
        do_read(A_CNT, rd);   check("cntwr_race", rd, 32'd5);
        do_tick(w0, w1);
        do_read(A_CNT, rd);   check("cntwr_next", rd, 32'd6);

        // Reset while counting
        do_tick(w0, w1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_wake", {31'b0, wakeup_o}, 32'h0);
        reset = 1'b0;
        do_read(A_CNT, rd);   check("midrst_count", rd, 32'h0);
        do_read(A_STAT, rd);  check("midrst_status", rd, 32'h0);
        do_read(A_CTRL, rd);  check("midrst_ctrl", rd, 32'h0);

        // Threshold lowered below COUNT while counting
        arm(32'd10, 32'h1);
        for (int i = 0; i < 3; i++) do_tick(w0, w1);
        do_write(A_THR, 32'd2);
        do_tick(w0, w1);
        check("thrlow_wake", {31'b0, w0}, 32'h1);
        do_read(A_CNT, rd);   check("thrlow_count", rd, 32'd4);

        // Threshold 0 acts as 1
        arm(32'd0, 32'h1);
        do_tick(w0, w1);
        check("thr0_wake", {31'b0, w0}, 32'h1);

        // COUNT wrap without expiry
        arm(32'hFFFF_FFFF, 32'h1);
        do_write(A_CNT, 32'hFFFF_FFFF);
        do_tick(w0, w1);
        check("wrap_wake", {31'b0, w0}, 32'h0);
        do_read(A_CNT, rd);   check("wrap_count", rd, 32'h0);
        do_write(A_CTRL, 32'h0);

`ifdef AON_TIMER_AUTORELOAD_EN
        arm(32'd2, 32'h3);
        for (int i = 1; i <= 4; i++) begin
            do_tick(w0, w1);
            check($sformatf("ar_wake_%0d", i), {31'b0, w0}, {31'b0, (i % 2 == 0)});
            do_read(A_CNT, rd);
            check($sformatf("ar_count_%0d", i), rd, 32'(i % 2));
        end
        do_write(A_CTRL, 32'h0);
        idle(2);
`else
        do_write(A_CTRL, 32'h2);
        do_read(A_CTRL, rd);  check("ar_off_readback", rd, 32'h0);
`endif

        // Randomized one-shot trials
        for (int t = 0; t < 6; t++) begin
            p     = int'($urandom_range(0, 3));
            thr   = int'($urandom_range(1, 5));
            total = (p + 1) * thr;
            arm(32'(thr), 32'h1 | (32'(p) << 8));
            for (int i = 1; i <= total; i++) begin
                do_tick(w0, w1);
                check($sformatf("rnd%0d_wake_%0d", t, i), {31'b0, w0}, {31'b0, (i == total)});
                do_read(A_CNT, rd);
                check($sformatf("rnd%0d_count_%0d", t, i), rd, 32'(i / (p + 1)));
            end
            do_read(A_STAT, rd);
            check($sformatf("rnd%0d_status", t), rd, 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
